register_bank: RTL
==================

Name: register_bank

Overview:
- Holds the processor's general and special registers at indices 1..14 of the 16-entry one-hot select space.
- Index 0 is AC and index 15 is DR; both live outside this block.
- Consumes the bus output word as its write data, and supplies the combined register word to the bus as Register_file.
- Controlled each cycle by one-hot write, increment and clear strobes from the control unit.

Parameters:
- Reg_count, 16, width of every one-hot select vector; entries 0 and Reg_count-1 are not stored here.
- reg_width, 12, data width of every register and of the bus.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- datain  input  reg_width  bus word (Data_bus dataout) written on write strobe.
- write_en  input  Reg_count  one-hot write strobe; bit i loads register i from datain.
- inc_en  input  Reg_count  bit i increments register i by 1.
- clr_en  input  Reg_count  bit i clears register i to 0.
- read_en  input  Reg_count  same vector driven to Data_bus; selects the Register_file output.
- err_clr  input  1  synchronous clear of multi_write_err.
- Register_file  output  reg_width  selected register value, combinational from stored state.
- multi_write_err  output  1  sticky flag; more than one write_en bit in [Reg_count-2:1] was seen.

Behaviour:
- Storage is registers 1..Reg_count-2, each reg_width bits.
- Strobe bits 0 and Reg_count-1 are ignored by all update and read logic.
- Reset (reset=0, asynchronous):
  - all registers become 0;
  - multi_write_err becomes 0;
  - Register_file shows 0 while reset is low.
  - Reset asserted mid-operation discards any update due on the next edge.
- Per register i, priority on each rising edge: clr_en[i] > write_en[i] > inc_en[i] > hold.
  - clr: reg <= 0.
  - write: reg <= datain.
  - inc: reg <= reg + 1, modulo 2^reg_width; 0xFFF wraps to 0x000, with no carry output.
- Registers update independently; any mix of different indices in one cycle is legal.
- Multiple write_en bits set in the same cycle:
  - every selected register loads datain (broadcast);
  - multi_write_err is set on that edge.
- multi_write_err:
  - once set, stays at 1 until err_clr=1 at a rising edge or reset;
  - if err_clr and a new multi-write happen in the same cycle, set wins and the flag stays 1.
- Read path (combinational, zero latency):
  - Register_file = register at the lowest set index among read_en[Reg_count-2:1];
  - if no bit in that range is set, Register_file = 0.
  - read_en bits 0 and 15 are ignored here; Data_bus gives them priority.
- Read-during-update: Register_file shows the pre-edge value until the edge; the new value is visible from the next cycle (write-to-read latency 1 cycle).
- No X propagation: every output is defined in every cycle after reset.

Test Plan:
- Reset: hold reset=0 with write_en=16'h0002 and datain=12'hABC -> Register_file=0 for read_en=16'h0002 and multi_write_err=0. Release reset; after one clock register 1 reads 12'hABC.
- Write/read all: for i=1..14 write datain=12'h100+i at write_en=1<<i, then read each -> value 12'h100+i. Also drive read_en=16'h0001 and 16'h8000 -> Register_file=0; write_en bits 0/15 change nothing.
- Increment wrap: write 12'hFFE to register 1, then inc_en[1] for 3 cycles -> reads 12'hFFF, 12'h000, 12'h001.
- Priority: register 2 holds 12'h055; in the same cycle drive clr_en[2], write_en[2] (datain=12'h3C3) and inc_en[2] -> 12'h000. Next cycle drive write_en[2] and inc_en[2] together -> 12'h3C3.
- Multi-write: write_en=16'h0006 with datain=12'h7A5 -> registers 1 and 2 both read 12'h7A5 and multi_write_err=1.
  - Flag stays 1 over idle cycles.
  - err_clr=1 -> flag 0 on the next edge.
  - err_clr together with write_en=16'h0018 -> flag stays 1.
- Async reset mid-op: inc_en[3] active each cycle with register 3 at 12'h010; drop reset between edges -> register 3 reads 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/register_bank.sv
// Processor register file for indices 1..Reg_count-2 of the one-hot select space.
// Per-register clear/write/increment updates, lowest-index combinational read, sticky multi-write flag.
module register_bank #(
  parameter int Reg_count = 16,
  parameter int reg_width = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [reg_width-1:0] datain,
  input  logic [Reg_count-1:0] write_en,
  input  logic [Reg_count-1:0] inc_en,
  input  logic [Reg_count-1:0] clr_en,
  input  logic [Reg_count-1:0] read_en,
  input  logic                 err_clr,
  output logic [reg_width-1:0] Register_file,
  output logic                 multi_write_err
);

  localparam int SelW = Reg_count - 2;
  localparam logic [SelW-1:0] SelOne = SelW'(1);
  localparam logic [reg_width-1:0] RegOne = reg_width'(1);

  logic [reg_width-1:0] regs [1:Reg_count-2];
  logic [SelW-1:0]      write_sel;
  logic                 multi_write;
  logic [reg_width-1:0] read_data;
  logic                 unused_strobes;

  assign write_sel = write_en[Reg_count-2:1];
  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign multi_write = |(write_sel & (write_sel - SelOne));

  // AC and DR strobes belong to other blocks.
  assign unused_strobes = ^{write_en[0], write_en[Reg_count-1],
                            inc_en[0], inc_en[Reg_count-1],
                            clr_en[0], clr_en[Reg_count-1],
                            read_en[0], read_en[Reg_count-1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i <= Reg_count - 2; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i <= Reg_count - 2; i++) begin
        if (clr_en[i]) begin
          regs[i] <= '0;
        end else if (write_en[i]) begin
          regs[i] <= datain;
        end else if (inc_en[i]) begin
          regs[i] <= regs[i] + RegOne;
        end
      end
    end
  end

  // A new multi-write in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      multi_write_err <= 1'b0;
    end else if (multi_write) begin
      multi_write_err <= 1'b1;
    end else if (err_clr) begin
      multi_write_err <= 1'b0;
    end
  end

  // Scanning downward lets the lowest selected index win.
  always_comb begin
    read_data = '0;
    for (int i = Reg_count - 2; i >= 1; i--) begin
      if (read_en[i]) begin
        read_data = regs[i];
      end
    end
  end

  assign Register_file = reset ? read_data : '0;

endmodule
